// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Owns the program counter, instruction register and data address register,
//   and runs single-word accesses to an external RAM that can add wait states
//   through mem_ready. Each access has three phases: issue (IDLE), wait for
//   ready (ACCESS), and one settle cycle (DONE). While an access is in flight,
//   stall asks the controller to hold its state.
//   Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access after
//   TIMEOUT ACCESS cycles without ready. An aborted access raises bus_err,
//   which stays set until reset.
module mem_access_unit #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16
`ifdef MEM_ACCESS_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic              addr_sel,
  input  logic              load_pc,
  input  logic              reset_pc,
  input  logic              load_ir,
  input  logic              load_addr,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_e;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] dar_q, dar_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              cmd_valid;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // The reserved encoding 2'b10 behaves like MNONE.
  assign cmd_valid = (mem_cmd == CMD_READ) || (mem_cmd == CMD_WRITE);

  // The controller holds while a command is being issued or an access is pending.
  assign stall = ((state_q == S_IDLE) && cmd_valid) || (state_q == S_ACCESS);

  // Access sequencer: latch address and data at issue, wait for ready, then settle for one cycle.
  always_comb begin
    // NOTE: each signal assigned here first gets its hold value, so no path leaves it
    // unassigned and no latch is inferred.
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    req_d      = req_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mem_addr_d = addr_sel ? pc_q : dar_q;
          wdata_d    = datapath_out;
          we_d       = (mem_cmd == CMD_WRITE);
          req_d      = 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
          tmo_d      = '0;
`endif
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          if (!we_q) rdata_d = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        // This cycle is the TIMEOUT-th one without ready, so abandon the access.
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural registers change only when the controller is not stalled.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    dar_d = dar_q;
    if (!stall) begin
      if (load_pc)   pc_d  = reset_pc ? '0 : pc_q + ADDR_W'(1);
      if (load_ir)   ir_d  = rdata_q;
      if (load_addr) dar_d = datapath_out[ADDR_W-1:0];
    end
  end

  // State and register storage; reset clears everything at once, even mid-access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      dar_q      <= '0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      dar_q      <= dar_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign read_data = rdata_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
  assign bus_err   = err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It runs directed vector tables, hand-written
// multi-cycle sequences, and random traffic compared against a transaction-level
// reference model. Timeout checks follow MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_unit;

  localparam int TIMEOUT_CYC = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mem_cmd = 2'b00;
  logic        addr_sel = 1'b0, load_pc = 1'b0, reset_pc = 1'b0;
  logic        load_ir = 1'b0, load_addr = 1'b0, mem_ready = 1'b0;
  logic [15:0] datapath_out = '0, mem_rdata = '0;
  logic [8:0]  mem_addr, pc;
  logic [15:0] mem_wdata, ir, read_data;
  logic        mem_req, mem_we, stall, bus_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .addr_sel(addr_sel),
    .load_pc(load_pc), .reset_pc(reset_pc), .load_ir(load_ir), .load_addr(load_addr),
    .datapath_out(datapath_out), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .pc(pc), .ir(ir), .read_data(read_data), .stall(stall), .bus_err(bus_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [4:0]  ctl;     // {addr_sel, load_pc, reset_pc, load_ir, load_addr}
    logic [15:0] dp;
    logic [15:0] rd;
    logic        rdy;
    logic [2:0]  e_srw;   // {stall before the edge, mem_req after, mem_we after}
    logic [8:0]  e_addr;
    logic [15:0] e_wdata;
    logic [8:0]  e_pc;
    logic [15:0] e_ir;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] c, input logic [4:0] ctl, input logic [15:0] dp,
                         input logic [15:0] rd, input logic rdy, input logic [2:0] srw,
                         input logic [8:0] a, input logic [15:0] wd, input logic [8:0] p,
                         input logic [15:0] i, input logic [15:0] r);
    vec_t v;
    v.cmd = c; v.ctl = ctl; v.dp = dp; v.rd = rd; v.rdy = rdy; v.e_srw = srw;
    v.e_addr = a; v.e_wdata = wd; v.e_pc = p; v.e_ir = i; v.e_rdata = r;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    mem_cmd = 2'b00; addr_sel = 1'b0; load_pc = 1'b0; reset_pc = 1'b0;
    load_ir = 1'b0; load_addr = 1'b0; mem_ready = 1'b0;
    datapath_out = '0; mem_rdata = '0;
  endtask

  // Pulses reset between clock edges. Returns on a falling edge.
  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  // Reference model state: the architectural registers plus the access in flight.
  logic [8:0]  m_pc, m_dar, m_addr;
  logic [15:0] m_ir, m_rd, m_wd;
  logic        m_req, m_we, m_err;
  bit          m_busy, m_settle;
  int          m_wait;

  function automatic bit model_stall();
    return m_busy || (!m_settle && (mem_cmd == 2'b01 || mem_cmd == 2'b11));
  endfunction

  task automatic model_clear();
    m_pc = '0; m_dar = '0; m_addr = '0; m_ir = '0; m_rd = '0; m_wd = '0;
    m_req = 1'b0; m_we = 1'b0; m_err = 1'b0; m_busy = 0; m_settle = 0; m_wait = 0;
  endtask

  // Advances the model by one clock edge, using the inputs held across that edge.
  task automatic model_edge();
    bit hold;
    hold = model_stall();
    if (!hold) begin
      if (load_pc)   m_pc  = reset_pc ? 9'd0 : 9'((int'(m_pc) + 1) % 512);
      if (load_ir)   m_ir  = m_rd;
      if (load_addr) m_dar = datapath_out[8:0];
    end
    if (m_busy) begin
      if (mem_ready) begin
        if (!m_we) m_rd = mem_rdata;
        m_busy = 0; m_settle = 1; m_req = 1'b0; m_we = 1'b0;
      end else begin
        m_wait++;
`ifdef MEM_ACCESS_TIMEOUT_EN
        if (m_wait == TIMEOUT_CYC) begin
          m_busy = 0; m_settle = 1; m_req = 1'b0; m_we = 1'b0; m_err = 1'b1;
        end
`endif
      end
    end else if (m_settle) begin
      m_settle = 0;
    end else if (mem_cmd == 2'b01 || mem_cmd == 2'b11) begin
      m_addr = addr_sel ? m_pc : m_dar;
      m_wd   = datapath_out;
      m_we   = (mem_cmd == 2'b11);
      m_req  = 1'b1;
      m_busy = 1; m_wait = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] saved_rd;
    int n;

    // Asynchronous reset must act before the first clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst.pc", pc, 0);           check("rst.ir", ir, 0);
    check("rst.read_data", read_data, 0); check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_wdata", mem_wdata, 0); check("rst.mem_req", mem_req, 0);
    check("rst.mem_we", mem_we, 0);   check("rst.bus_err", bus_err, 0);
    check("rst.stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset during an access that is waiting for ready.
    load_pc = 1'b1;
    repeat (2) @(negedge clk);
    load_pc = 1'b0;
    mem_cmd = 2'b01; addr_sel = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("midrst.req_issued", mem_req, 1);
    check("midrst.addr_pc", mem_addr, 2);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("midrst.req_async", mem_req, 0);
    check("midrst.pc", pc, 0);
    check("midrst.mem_addr", mem_addr, 0);
    mem_cmd = 2'b00;
    #1;
    check("midrst.stall_idle", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    do_reset();

    // Directed vectors: zero-wait read, write with three wait states, reserved command, PC control.
    for (int k = 1; k <= 5; k++)
      add_vec(2'b00, 5'b01000, 16'h0, 16'h0, 1'b0, 3'b000, 9'h000, 16'h0, 9'(k), 16'h0, 16'h0);
    add_vec(2'b01, 5'b10000, 16'h0000, 16'hA5C3, 1'b1, 3'b110, 9'h005, 16'h0000, 9'h005, 16'h0000, 16'h0000);
    add_vec(2'b01, 5'b11000, 16'h0000, 16'hA5C3, 1'b1, 3'b100, 9'h005, 16'h0000, 9'h005, 16'h0000, 16'hA5C3);
    add_vec(2'b01, 5'b00010, 16'h0000, 16'h0000, 1'b0, 3'b000, 9'h005, 16'h0000, 9'h005, 16'hA5C3, 16'hA5C3);
    add_vec(2'b00, 5'b00001, 16'h0042, 16'h0000, 1'b0, 3'b000, 9'h005, 16'h0000, 9'h005, 16'hA5C3, 16'hA5C3);
    add_vec(2'b11, 5'b00000, 16'h1234, 16'h0000, 1'b1, 3'b111, 9'h042, 16'h1234, 9'h005, 16'hA5C3, 16'hA5C3);
    for (int k = 0; k < 3; k++)
      add_vec(2'b11, 5'b01000, 16'hFFFF, 16'h0000, 1'b0, 3'b111, 9'h042, 16'h1234, 9'h005, 16'hA5C3, 16'hA5C3);
    add_vec(2'b11, 5'b00000, 16'hFFFF, 16'hBEEF, 1'b1, 3'b100, 9'h042, 16'h1234, 9'h005, 16'hA5C3, 16'hA5C3);
    add_vec(2'b00, 5'b00000, 16'h0000, 16'h0000, 1'b0, 3'b000, 9'h042, 16'h1234, 9'h005, 16'hA5C3, 16'hA5C3);
    add_vec(2'b10, 5'b01000, 16'h0000, 16'h0000, 1'b0, 3'b000, 9'h042, 16'h1234, 9'h006, 16'hA5C3, 16'hA5C3);
    add_vec(2'b10, 5'b01000, 16'h0000, 16'h0000, 1'b0, 3'b000, 9'h042, 16'h1234, 9'h007, 16'hA5C3, 16'hA5C3);
    add_vec(2'b00, 5'b01100, 16'h0000, 16'h0000, 1'b0, 3'b000, 9'h042, 16'h1234, 9'h000, 16'hA5C3, 16'hA5C3);

    for (int i = 0; i < vecs.size(); i++) begin
      mem_cmd = vecs[i].cmd;
      {addr_sel, load_pc, reset_pc, load_ir, load_addr} = vecs[i].ctl;
      datapath_out = vecs[i].dp; mem_rdata = vecs[i].rd; mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d.stall", i), stall, vecs[i].e_srw[2]);
      @(posedge clk); #1;
      check($sformatf("vec%0d.mem_req", i), mem_req, vecs[i].e_srw[1]);
      check($sformatf("vec%0d.mem_we", i), mem_we, vecs[i].e_srw[0]);
      check($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d.ir", i), ir, vecs[i].e_ir);
      check($sformatf("vec%0d.read_data", i), read_data, vecs[i].e_rdata);
      check($sformatf("vec%0d.bus_err", i), bus_err, 0);
      @(negedge clk);
    end

    // PC wrap: 511 increments from 0 reach all-ones, and one more wraps to 0.
    idle_inputs();
    load_pc = 1'b1;
    repeat (511) @(posedge clk);
    #1 check("wrap.pc_max", pc, 9'h1FF);
    @(posedge clk); #1;
    check("wrap.pc_zero", pc, 0);
    load_pc = 1'b0;
    @(negedge clk);

    // Read with mem_ready stuck low.
    saved_rd = read_data;
    mem_cmd = 2'b01; addr_sel = 1'b1; mem_ready = 1'b0;
    n = 0;
    while (n < 100) begin
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
      mem_cmd = 2'b00;
    end
`ifdef MEM_ACCESS_TIMEOUT_EN
    check("tmo.stall_cycles", n, TIMEOUT_CYC + 1);
    check("tmo.bus_err", bus_err, 1);
    check("tmo.mem_req", mem_req, 0);
    check("tmo.read_data_kept", read_data, saved_rd);
    @(posedge clk); #1;
    check("tmo.bus_err_sticky", bus_err, 1);
    @(negedge clk);
    mem_cmd = 2'b01; mem_ready = 1'b1; mem_rdata = 16'h1357;
    @(posedge clk); @(posedge clk); #1;
    mem_cmd = 2'b00; mem_ready = 1'b0;
    check("tmo.next_read_data", read_data, 16'h1357);
    check("tmo.next_req_done", mem_req, 0);
    check("tmo.bus_err_still", bus_err, 1);
    @(negedge clk);
`else
    check("notmo.stall_cycles", n, 100);
    check("notmo.stall_high", stall, 1);
    check("notmo.mem_req", mem_req, 1);
    check("notmo.bus_err", bus_err, 0);
    mem_ready = 1'b1; mem_rdata = 16'h2468;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("notmo.completes", mem_req, 0);
    check("notmo.read_data", read_data, 16'h2468);
    @(negedge clk);
`endif

    // Random traffic compared against the reference model.
    do_reset();
    model_clear();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      mem_cmd      = 2'($urandom_range(0, 3));
      addr_sel     = 1'($urandom_range(0, 1));
      load_pc      = 1'($urandom_range(0, 1));
      reset_pc     = ($urandom_range(0, 3) == 0);
      load_ir      = 1'($urandom_range(0, 1));
      load_addr    = 1'($urandom_range(0, 1));
      datapath_out = 16'($urandom);
      mem_rdata    = 16'($urandom);
      mem_ready    = ((cyc % 400) < 40) ? 1'b0 : ($urandom_range(0, 9) < 6);
      #1;
      check("rnd.stall", stall, model_stall());
      @(posedge clk);
      model_edge();
      #1;
      check("rnd.mem_req", mem_req, m_req);
      check("rnd.mem_we", mem_we, m_we);
      check("rnd.we_only_with_req", mem_we & ~mem_req, 0);
      check("rnd.mem_addr", mem_addr, m_addr);
      check("rnd.mem_wdata", mem_wdata, m_wd);
      check("rnd.pc", pc, m_pc);
      check("rnd.ir", ir, m_ir);
      check("rnd.read_data", read_data, m_rd);
      check("rnd.bus_err", bus_err, m_err);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
